// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npc_pkg
//  Description : Shared constants and types for the NPC core memory path.
//                Holds the error-fetch instruction, the default RAM base
//                address and the fetch-responder state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

  // addi x0, x0, 0 -- handed back on any rejected fetch
  localparam logic [31:0] NOP_INST      = 32'h0000_0013;

  // Byte address that maps to RAM word 0
  localparam logic [31:0] BASE_ADDR_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_ERR  = 2'd2,
    ST_RESP = 2'd3
  } fetch_state_e;

endpackage : npc_pkg
`default_nettype wire

// File: rtl/imem_addr_check.sv
`default_nettype none
// ============================================================================
//  Module      : imem_addr_check
//  Description : Combinational PC decode for a word-addressed RAM window.
//                Reports alignment, whether the PC lies inside
//                [BASE_ADDR, BASE_ADDR + 4*2^ADDR_W) and the RAM word index.
//                Shared by the instruction and data memory paths.
//  Ports       : req_pc   - byte address to decode
//                in_range - address falls inside the RAM window
//                aligned  - address is 4-byte aligned
//                word_idx - RAM word index (only meaningful when in_range)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_addr_check #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = npc_pkg::BASE_ADDR_DEF
) (
  input  logic [31:0]       req_pc,
  output logic              in_range,
  output logic              aligned,
  output logic [ADDR_W-1:0] word_idx
);

  // BASE_ADDR is assumed word-aligned and ADDR_W <= 29, so the offset can be
  // taken on word addresses directly. Any offset bit above the RAM index
  // means the PC is past the end of the window.
  logic [29:0] w_word_off;

  assign w_word_off = req_pc[31:2] - BASE_ADDR[31:2];
  assign aligned    = (req_pc[1:0] == 2'b00);
  // The explicit lower-bound compare rejects PCs below the base, whose
  // subtraction would otherwise wrap into a small-looking offset.
  assign in_range   = (req_pc >= BASE_ADDR) && (w_word_off[29:ADDR_W] == '0);
  assign word_idx   = w_word_off[ADDR_W-1:0];

endmodule : imem_addr_check
`default_nettype wire

// File: rtl/imem_fetch_resp.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_resp
//  Description : Instruction-memory responder for the NPC core fetch stage.
//                Accepts a byte PC on a valid/ready request channel, reads a
//                block RAM with 1-cycle synchronous read latency and returns
//                the instruction on a valid/ready response channel. Bad PCs
//                (misaligned / out of window) return NOP_INST with resp_err
//                after the same latency as a good fetch. A single-cycle
//                word-write load port shares the RAM port and wins over
//                fetch requests when both arrive in IDLE.
//  Ports       : clk, rst                   - clock, sync active-high reset
//                req_valid/req_ready/req_pc - fetch request channel
//                resp_valid/resp_ready      - fetch response channel
//                resp_inst/resp_err         - response payload
//                ld_valid/ld_ready          - RAM load channel
//                ld_addr/ld_data            - load word index and data
//                ram_addr/ram_wen/ram_din   - block RAM port A inputs
//                ram_dout                   - block RAM port A read data
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_resp #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = npc_pkg::BASE_ADDR_DEF,
  parameter logic [31:0] NOP_INST  = npc_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  // fetch request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_pc,
  // fetch response
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_inst,
  output logic              resp_err,
  // RAM load port
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  // block RAM port A
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_wen,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  import npc_pkg::*;

  fetch_state_e      state_q;
  logic              resp_valid_q;
  logic [31:0]       resp_inst_q;
  logic              resp_err_q;

  logic              w_in_range;
  logic              w_aligned;
  logic [ADDR_W-1:0] w_word_idx;
  logic              w_pc_good;
  logic              w_idle;
  logic              w_ld_fire;
  logic              w_req_fire;

  // --------------------------------------------------------------------------
  // PC decode
  // --------------------------------------------------------------------------
  imem_addr_check #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_check (
    .req_pc   (req_pc),
    .in_range (w_in_range),
    .aligned  (w_aligned),
    .word_idx (w_word_idx)
  );

  assign w_pc_good = w_in_range && w_aligned;

  // --------------------------------------------------------------------------
  // Handshakes. Both channels are only open in IDLE; the load port has
  // priority, so a pending load stalls a request for that cycle.
  // --------------------------------------------------------------------------
  assign w_idle     = (state_q == ST_IDLE);
  assign ld_ready   = w_idle;
  assign req_ready  = w_idle && !ld_valid;
  assign w_ld_fire  = ld_ready && ld_valid;
  assign w_req_fire = req_ready && req_valid;

  // --------------------------------------------------------------------------
  // RAM port mux. The RAM registers its address on the same edge that the
  // handshake completes, so address/write data must be driven
  // combinationally in the handshake cycle. Everything is forced idle while
  // rst is high so a load presented during reset cannot corrupt the RAM.
  // --------------------------------------------------------------------------
  always_comb begin
    ram_addr = '0;
    ram_wen  = 4'h0;
    ram_din  = 32'h0;
    if (!rst) begin
      if (w_ld_fire) begin
        ram_addr = ld_addr;
        ram_wen  = 4'hF;
        ram_din  = ld_data;
      end else if (w_req_fire && w_pc_good) begin
        ram_addr = w_word_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM and response register.
  // READ and ERR both take exactly one cycle so good and bad PCs see the
  // same request-to-response latency (handshake at T, resp_valid at T+2).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= NOP_INST;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_req_fire) begin
            state_q <= w_pc_good ? ST_READ : ST_ERR;
          end
        end
        ST_READ: begin
          // ram_dout now holds the word addressed in the handshake cycle
          resp_inst_q  <= ram_dout;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_ERR: begin
          resp_inst_q  <= NOP_INST;
          resp_err_q   <= 1'b1;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          // payload is left untouched so it stays stable under backpressure
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_inst  = resp_inst_q;
  assign resp_err   = resp_err_q;

endmodule : imem_fetch_resp
`default_nettype wire

// File: tb/tb_imem_fetch_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_resp
//  Description : Self-checking bench for imem_fetch_resp. Includes a
//                behavioural block RAM, a directed vector table, hand-written
//                corner-case sequences and a randomized phase checked against
//                a simple array-based reference of the memory map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_resp;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_pc;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_inst;
  logic              resp_err;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_wen;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_fetch_resp #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE),
    .NOP_INST  (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_inst  (resp_inst),
    .resp_err   (resp_err),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ram_addr   (ram_addr),
    .ram_wen    (ram_wen),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  // Behavioural block RAM: byte-enabled write, registered read
  logic [31:0] bram [DEPTH] = '{default: 32'h0};
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wen[b]) bram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
    ram_dout <= bram[ram_addr];
  end

  // Reference model: what the memory map should contain, updated per load
  logic [31:0] model_mem [DEPTH] = '{default: 32'h0};

  function automatic void ref_fetch(input logic [31:0] pc,
                                    output logic [31:0] inst,
                                    output logic err);
    longint unsigned p;
    p = longint'(pc);
    if ((pc % 4) != 0 || p < longint'(BASE) || p >= longint'(BASE) + 4 * DEPTH) begin
      inst = NOP;
      err  = 1'b1;
    end else begin
      inst = model_mem[(p - longint'(BASE)) / 4];
      err  = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One-cycle load; returns just after the write edge with ld_valid low
  task automatic do_load(input logic [ADDR_W-1:0] a, input logic [31:0] d, input string tag);
    @(negedge clk);
    req_valid = 1'b0;
    ld_valid  = 1'b1;
    ld_addr   = a;
    ld_data   = d;
    #1;
    chk({tag, ".ld_ready"}, ld_ready, 1);
    chk({tag, ".ram_wen"}, ram_wen, 4'hF);
    chk({tag, ".ram_addr"}, ram_addr, a);
    chk({tag, ".ram_din"}, ram_din, d);
    @(posedge clk);
    #1 ld_valid = 1'b0;
    model_mem[a] = d;
  endtask

  // Called right after the request handshake edge (cycle T).
  task automatic wait_resp(input logic [31:0] e_inst, input logic e_err,
                           input int delay, input string tag);
    @(negedge clk);                       // cycle T+1
    req_valid = 1'b0;
    chk({tag, ".t1_valid"}, resp_valid, 0);
    chk({tag, ".t1_req_ready"}, req_ready, 0);
    chk({tag, ".t1_wen"}, ram_wen, 0);
    @(negedge clk);                       // cycle T+2
    chk({tag, ".valid"}, resp_valid, 1);
    chk({tag, ".inst"}, resp_inst, e_inst);
    chk({tag, ".err"}, resp_err, e_err);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, resp_valid, 1);
      chk({tag, ".hold_inst"}, resp_inst, e_inst);
      chk({tag, ".hold_req_ready"}, req_ready, 0);
      chk({tag, ".hold_ld_ready"}, ld_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".done_valid"}, resp_valid, 0);
    chk({tag, ".done_req_ready"}, req_ready, 1);
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int delay,
                          input logic [31:0] e_inst, input logic e_err, input string tag);
    @(negedge clk);
    ld_valid   = 1'b0;
    req_valid  = 1'b1;
    req_pc     = pc;
    resp_ready = 1'b0;
    #1;
    chk({tag, ".req_ready"}, req_ready, 1);
    chk({tag, ".hs_wen"}, ram_wen, 0);
    if (e_err) chk({tag, ".hs_addr_idle"}, ram_addr, 0);
    else       chk({tag, ".hs_addr"}, ram_addr, (pc - BASE) / 4);
    @(posedge clk);
    wait_resp(e_inst, e_err, delay, tag);
  endtask

  typedef struct {
    bit          is_load;
    logic [31:0] a;       // word index for loads, byte PC for fetches
    logic [31:0] d;
    int          delay;
    logic [31:0] e_inst;
    logic        e_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_inst;
    logic        e_err;
    logic [31:0] pc;
    logic [31:0] edge_pcs [6];

    vecs[0] = '{1'b1, 32'd5,          32'h0050_0093, 0, 32'h0,          1'b0};
    vecs[1] = '{1'b1, 32'd1023,       32'h3FF0_0113, 0, 32'h0,          1'b0};
    vecs[2] = '{1'b0, 32'h8000_0014,  32'h0,         0, 32'h0050_0093,  1'b0};
    vecs[3] = '{1'b0, 32'h8000_0002,  32'h0,         0, 32'h0000_0013,  1'b1};
    vecs[4] = '{1'b0, 32'h8000_1000,  32'h0,         0, 32'h0000_0013,  1'b1};
    vecs[5] = '{1'b0, 32'h7FFF_FFFC,  32'h0,         0, 32'h0000_0013,  1'b1};
    vecs[6] = '{1'b0, 32'h8000_0FFC,  32'h0,         0, 32'h3FF0_0113,  1'b0};
    vecs[7] = '{1'b0, 32'h8000_0000,  32'h0,         1, 32'h0000_0000,  1'b0};
    vecs[8] = '{1'b0, 32'h8000_0014,  32'h0,         5, 32'h0050_0093,  1'b0};

    edge_pcs = '{32'h7FFF_FFFC, 32'h8000_1000, 32'h8000_0FFC,
                 32'h8000_0000, 32'hFFFF_FFFC, 32'h0000_0000};

    rst = 1'b1; req_valid = 1'b0; req_pc = 32'h0; resp_ready = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.resp_valid", resp_valid, 0);
    chk("reset.resp_inst", resp_inst, NOP);
    chk("reset.resp_err", resp_err, 0);
    chk("reset.req_ready", req_ready, 1);
    chk("reset.ld_ready", ld_ready, 1);
    chk("reset.ram_wen", ram_wen, 0);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_load)
        do_load(vecs[i].a[ADDR_W-1:0], vecs[i].d, $sformatf("vec%0d", i));
      else
        do_fetch(vecs[i].a, vecs[i].delay, vecs[i].e_inst, vecs[i].e_err,
                 $sformatf("vec%0d", i));
    end

    // Load immediately followed by a fetch of the same word
    do_load(10'd9, 32'h0090_0493, "ldfetch");
    do_fetch(32'h8000_0024, 0, 32'h0090_0493, 1'b0, "ldfetch");

    // Load and request together: load wins, request follows next cycle
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 10'd7; ld_data = 32'hCAFE_0713;
    req_valid = 1'b1; req_pc = 32'h8000_001C; resp_ready = 1'b0;
    #1;
    chk("simul.req_ready", req_ready, 0);
    chk("simul.ld_ready", ld_ready, 1);
    chk("simul.wen", ram_wen, 4'hF);
    chk("simul.ld_addr", ram_addr, 7);
    @(posedge clk);
    #1 ld_valid = 1'b0;
    model_mem[7] = 32'hCAFE_0713;
    @(negedge clk);
    chk("simul.req_ready2", req_ready, 1);
    chk("simul.rd_addr", ram_addr, 7);
    @(posedge clk);
    wait_resp(32'hCAFE_0713, 1'b0, 1, "simul");

    // Reset while holding a response; a load during reset must not write
    @(negedge clk);
    req_valid = 1'b1; req_pc = 32'h8000_0014; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstresp.valid_before", resp_valid, 1);
    rst = 1'b1; ld_valid = 1'b1; ld_addr = 10'd5; ld_data = 32'hFFFF_FFFF;
    #1;
    chk("rstresp.wen_in_rst", ram_wen, 0);
    @(posedge clk);
    #1 ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstresp.valid", resp_valid, 0);
    chk("rstresp.inst", resp_inst, NOP);
    chk("rstresp.req_ready", req_ready, 1);
    chk("rstresp.ld_ready", ld_ready, 1);
    do_fetch(32'h8000_0014, 0, 32'h0050_0093, 1'b0, "rstresp.after");

    // Randomized loads and fetches against the reference model
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_load(10'($urandom_range(0, DEPTH - 1)), $urandom(), $sformatf("rnd%0d.ld", it));
      end else begin
        case ($urandom_range(0, 4))
          0, 1: pc = BASE + 4 * $urandom_range(0, DEPTH - 1);
          2:    pc = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
          3:    pc = $urandom();
          default: pc = edge_pcs[$urandom_range(0, 5)];
        endcase
        ref_fetch(pc, e_inst, e_err);
        do_fetch(pc, $urandom_range(0, 3), e_inst, e_err, $sformatf("rnd%0d.pc%h", it, pc));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_imem_fetch_resp
`default_nettype wire

// File: doc/imem_fetch_resp.md
Name: imem_fetch_resp

Overview:
Instruction-memory responder that serves the NPC core's fetch requests. It accepts a byte PC over a valid/ready request channel and reads the 32x1024 block RAM (1-cycle synchronous read). It returns the instruction over a valid/ready response channel, and flags misaligned or out-of-range PCs. A word-write load port lets the testbench or boot logic fill the RAM before or between fetches.

Parameters:
ADDR_W, 10, word-address width of the block RAM (depth 2^ADDR_W words)
BASE_ADDR, 32'h8000_0000, byte address mapped to RAM word 0
NOP_INST, 32'h0000_0013, instruction returned on error (addi x0,x0,0)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  fetch request valid
req_ready  output  1  responder can accept a request this cycle
req_pc  input  32  byte PC to fetch
resp_valid  output  1  response valid
resp_ready  input  1  core accepts response
resp_inst  output  32  fetched instruction
resp_err  output  1  1 = misaligned or out-of-range PC
ld_valid  input  1  load write valid
ld_ready  output  1  load write accepted this cycle
ld_addr  input  ADDR_W  RAM word index to write
ld_data  input  32  word to write
ram_addr  output  ADDR_W  to BLK_RAM addra
ram_wen  output  4  to BLK_RAM wea (byte enables)
ram_din  output  32  to BLK_RAM dina
ram_dout  input  32  from BLK_RAM douta, valid one cycle after address edge

Behaviour:
- Reset, synchronous:
  - state=IDLE, resp_valid=0, resp_inst=NOP_INST, resp_err=0.
  - ram_wen=0 while rst is high.
  - Any in-flight read or held response is discarded.
- States: IDLE, READ, RESP, ERR.
- IDLE:
  - ld_ready=1, always.
  - req_ready = !ld_valid (load has priority).
- Load accepted (IDLE and ld_valid):
  - ram_addr=ld_addr, ram_wen=4'hF, ram_din=ld_data, combinational in that cycle.
  - State stays IDLE. Single-cycle write.
- Request accepted (IDLE, req_valid, !ld_valid) with good PC:
  - good PC = req_pc[1:0]==0 and BASE_ADDR <= req_pc < BASE_ADDR + 4*2^ADDR_W.
  - ram_addr = (req_pc-BASE_ADDR)[ADDR_W+1:2], driven combinationally; next state READ.
- Request accepted with bad PC:
  - No RAM access; next state ERR.
- READ, one cycle:
  - resp_inst <= ram_dout, resp_err <= 0; next state RESP.
- ERR, one cycle:
  - resp_inst <= NOP_INST, resp_err <= 1; next state RESP.
  - Latency is therefore equal for good and bad PCs.
- RESP:
  - resp_valid=1; resp_inst/resp_err held stable until resp_valid && resp_ready; then IDLE.
  - req_ready=0 and ld_ready=0 in READ, ERR and RESP.
- Timing: request handshake in cycle T -> resp_valid first high in cycle T+2. Max throughput is 1 fetch per 3 cycles with resp_ready tied high.
- RAM port default outside load/request cycles: ram_addr=0, ram_wen=0, ram_din=0. ram_wen is never nonzero outside IDLE.
- Address arithmetic: 32-bit unsigned subtraction with no wrap acceptance.
  - req_pc < BASE_ADDR is out of range.
  - The last valid PC is BASE_ADDR + 4*2^ADDR_W - 4.
- Simultaneous ld_valid and req_valid in IDLE: load is written, request is stalled (req_ready=0). The request is accepted the next cycle if ld_valid has dropped.
- Load then fetch of the same word on the next cycle returns the new data.
- resp_valid never deasserts without a handshake, except on rst.

Decomposition:
- Shared package npc_pkg holds:
  - NOP_INST constant
  - BASE_ADDR default
  - fetch-responder state encoding (IDLE=0, READ=1, ERR=2, RESP=3)
- One natural sub-module: imem_addr_check, combinational. Inputs req_pc; outputs in_range, aligned, word_idx[ADDR_W-1:0]. It is reused later by the data-memory path.
- The FSM, response register and RAM port mux stay in imem_fetch_resp.

Test Plan:
- Load word 5 = 32'h00500093 (ld_valid one cycle), then fetch pc=32'h8000_0014 with resp_ready=1 -> resp_valid at T+2, resp_inst=32'h00500093, resp_err=0.
- Fetch pc=32'h8000_0002 -> resp_inst=32'h00000013, resp_err=1 at T+2; ram_wen stays 0 and no RAM read is issued.
- Fetch pc=32'h8000_1000 (one past end) and pc=32'h7FFF_FFFC -> both resp_err=1; pc=32'h8000_0FFC -> resp_err=0, returns word 1023.
- Fetch with resp_ready=0 for 5 cycles -> resp_valid and resp_inst stable; req_ready=0 and ld_ready=0 throughout; completes on the cycle resp_ready rises.
- ld_valid and req_valid asserted together in IDLE -> load written, req_ready=0. Next cycle the request is accepted and returns the newly loaded data.
- Assert rst while in RESP -> the next cycle has resp_valid=0, resp_inst=32'h00000013, state IDLE, req_ready=1.
